// File: rtl/axis_rr_arbiter.sv
`default_nettype none
//============================================================================
//  Module   : axis_rr_arbiter
//  Purpose  : Packet-locked round-robin arbiter sharing one AXI-stream sink
//             between NUM_REQ requesters. A grant is held until the granted
//             requester's last beat transfers or until MAX_BURST beats have
//             transferred (MAX_BURST = 0 disables the beat limit).
//  Revision : 1.0 - initial release
//----------------------------------------------------------------------------
//  Ports
//    aclk      in   1                    clock, rising edge
//    aresetn   in   1                    synchronous active-low reset
//    s_data    in   NUM_REQ*DATA_WIDTH   requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//    s_valid   in   NUM_REQ              per-requester valid
//    s_last    in   NUM_REQ              per-requester end-of-packet
//    s_ready   out  NUM_REQ              per-requester ready (granted one only)
//    m_data    out  DATA_WIDTH           granted data
//    m_valid   out  1                    granted valid
//    m_last    out  1                    granted last
//    m_id      out  ID_W                 index of the granted requester
//    m_ready   in   1                    sink ready
//============================================================================
module axis_rr_arbiter #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    parameter  int MAX_BURST  = 16,
    localparam int ID_W       = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    output logic                          m_last,
    output logic [ID_W-1:0]               m_id,
    input  logic                          m_ready
);

    // Beat counter is wide enough to hold MAX_BURST, never narrower than 1.
    localparam int c_cnt_w = ($clog2(MAX_BURST + 1) > 1) ? $clog2(MAX_BURST + 1) : 1;
    // Counter value seen on the final beat of a full-length burst.
    localparam logic [c_cnt_w-1:0] c_burst_end = c_cnt_w'((MAX_BURST > 0) ? (MAX_BURST - 1) : 0);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    logic [ID_W-1:0]      r_grant;
    logic [ID_W-1:0]      r_last_grant;
    logic [c_cnt_w-1:0]   r_beat_cnt;

    logic [NUM_REQ-1:0]    w_upper_mask;
    logic [NUM_REQ-1:0]    w_hi_req;
    logic [ID_W-1:0]       w_pick_hi;
    logic [ID_W-1:0]       w_pick_lo;
    logic [ID_W-1:0]       w_next_grant;

    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [NUM_REQ-1:0]    w_grant_onehot;

    logic                  w_xfer;
    logic                  w_burst_end;
    logic                  w_end;

    //------------------------------------------------------------------------
    // Round-robin pick. Requesters above last_grant have priority; if none of
    // them is valid the search wraps to the lowest valid index. Iterating
    // downwards leaves the lowest set index in each pick register.
    //------------------------------------------------------------------------
    always_comb begin
        w_upper_mask = '0;
        w_pick_hi    = '0;
        w_pick_lo    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_upper_mask[i] = (ID_W'(i) > r_last_grant);
        end
        w_hi_req = s_valid & w_upper_mask;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_hi_req[i]) begin
                w_pick_hi = ID_W'(i);
            end
            if (s_valid[i]) begin
                w_pick_lo = ID_W'(i);
            end
        end
        w_next_grant = (|w_hi_req) ? w_pick_hi : w_pick_lo;
    end

    //------------------------------------------------------------------------
    // Select the currently granted requester's stream signals.
    //------------------------------------------------------------------------
    always_comb begin
        w_sel_data     = '0;
        w_sel_valid    = 1'b0;
        w_sel_last     = 1'b0;
        w_grant_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == ID_W'(i)) begin
                w_sel_data        = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_valid       = s_valid[i];
                w_sel_last        = s_last[i];
                w_grant_onehot[i] = 1'b1;
            end
        end
    end

    //------------------------------------------------------------------------
    // Output stage. m_valid depends only on state and s_valid, never on
    // m_ready; only s_ready follows m_ready combinationally.
    //------------------------------------------------------------------------
    always_comb begin
        m_data  = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_id    = r_grant;
        s_ready = '0;
        if (r_state == S_GRANT) begin
            m_data  = w_sel_data;
            m_valid = w_sel_valid;
            m_last  = w_sel_last;
            s_ready = w_grant_onehot & {NUM_REQ{m_ready}};
        end
    end

    assign w_xfer      = (r_state == S_GRANT) && w_sel_valid && m_ready;
    // A burst cut ends the grant without touching m_last; the requester
    // continues the same packet on its next grant.
    assign w_burst_end = (MAX_BURST > 0) && (r_beat_cnt == c_burst_end);
    assign w_end       = w_xfer && (w_sel_last || w_burst_end);

    //------------------------------------------------------------------------
    // Control FSM. IDLE always costs one cycle, giving one bubble per grant.
    //------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|s_valid) begin
                        r_grant <= w_next_grant;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_end) begin
                        r_last_grant <= r_grant;
                        r_beat_cnt   <= '0;
                        r_state      <= S_IDLE;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
`default_nettype none
//============================================================================
//  Module   : tb_axis_rr_arbiter
//  Purpose  : Self-checking bench for axis_rr_arbiter (NUM_REQ=4,
//             DATA_WIDTH=32, MAX_BURST=4). A vector table covers reset and
//             round-robin rotation; hand sequences cover packet lock,
//             backpressure, burst cut and reset mid-packet.
//  Revision : 1.0 - initial release
//============================================================================
module tb_axis_rr_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;

    logic             aclk;
    logic             aresetn;
    logic [NR*DW-1:0] s_data;
    logic [NR-1:0]    s_valid;
    logic [NR-1:0]    s_last;
    logic [NR-1:0]    s_ready;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic             m_last;
    logic [1:0]       m_id;
    logic             m_ready;

    int n_checks = 0;
    int n_pass   = 0;

    axis_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (4)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_id    (m_id),
        .m_ready (m_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        rstn;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        mr;
        logic [3:0]  e_sr;
        logic        e_mv;
        logic        e_ml;
        logic [31:0] e_md;
        logic [1:0]  e_id;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are already driven; compare at the falling edge, then let the
    // rising edge consume them.
    task automatic expect_out(input string name, input logic [3:0] sr, input logic mv,
                              input logic ml, input logic [31:0] md, input logic [1:0] id);
        @(negedge aclk);
        check({name, ".s_ready"}, 32'(s_ready), 32'(sr));
        check({name, ".m_valid"}, 32'(m_valid), 32'(mv));
        check({name, ".m_last"},  32'(m_last),  32'(ml));
        check({name, ".m_data"},  m_data,       md);
        check({name, ".m_id"},    32'(m_id),    32'(id));
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic mr);
        s_valid = v;
        s_last  = l;
        m_ready = mr;
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        s_data[i*DW +: DW] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            rstn  valid  last   mr    sr     mv    ml    data    id
        tbl[0]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 32'h00, 2'd0};
        tbl[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 32'h00, 2'd0};
        tbl[2]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1, 32'hA0, 2'd0};
        tbl[3]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 32'h00, 2'd0};
        tbl[4]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 1'b1, 32'hA1, 2'd1};
        tbl[5]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 32'h00, 2'd1};
        tbl[6]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 1'b1, 32'hA2, 2'd2};
        tbl[7]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 32'h00, 2'd2};
        tbl[8]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1, 32'hA3, 2'd3};
        tbl[9]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 32'h00, 2'd3};
        tbl[10] = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1, 32'hA0, 2'd0};
        tbl[11] = '{1'b1, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 32'h00, 2'd0};

        aresetn = 1'b0;
        s_valid = '0;
        s_last  = '0;
        m_ready = 1'b0;
        s_data  = '0;
        for (int i = 0; i < NR; i++) set_data(i, 32'hA0 + 32'(i));
        @(posedge aclk);
        #1;

        // Reset defaults and round-robin rotation.
        for (int k = 0; k < 12; k++) begin
            aresetn = tbl[k].rstn;
            drive(tbl[k].valid, tbl[k].last, tbl[k].mr);
            expect_out($sformatf("vec%0d", k), tbl[k].e_sr, tbl[k].e_mv,
                       tbl[k].e_ml, tbl[k].e_md, tbl[k].e_id);
        end

        // Packet lock: req1 single beat to move last_grant to 1, then a
        // 3-beat packet from req2 while req1 keeps requesting.
        set_data(1, 32'h110);
        drive(4'b0010, 4'b0010, 1'b1);
        expect_out("lock_a", 4'h0, 1'b0, 1'b0, 32'h0, 2'd0);
        expect_out("lock_b", 4'h2, 1'b1, 1'b1, 32'h110, 2'd1);
        set_data(2, 32'h120);
        drive(4'b0110, 4'b0010, 1'b1);
        expect_out("lock_c", 4'h0, 1'b0, 1'b0, 32'h0, 2'd1);
        expect_out("lock_d", 4'h4, 1'b1, 1'b0, 32'h120, 2'd2);
        set_data(2, 32'h121);
        expect_out("lock_e", 4'h4, 1'b1, 1'b0, 32'h121, 2'd2);
        set_data(2, 32'h122);
        drive(4'b0110, 4'b0110, 1'b1);
        expect_out("lock_f", 4'h4, 1'b1, 1'b1, 32'h122, 2'd2);
        drive(4'b0010, 4'b0010, 1'b1);
        expect_out("lock_g", 4'h0, 1'b0, 1'b0, 32'h0, 2'd2);
        expect_out("lock_h", 4'h2, 1'b1, 1'b1, 32'h110, 2'd1);

        // Backpressure: 5 stalled cycles on beat 2 of a non-last run from
        // req2; the cut must still land on the 4th transferred beat.
        set_data(2, 32'h200);
        drive(4'b0100, 4'b0000, 1'b1);
        expect_out("bp_idle", 4'h0, 1'b0, 1'b0, 32'h0, 2'd1);
        expect_out("bp_b1", 4'h4, 1'b1, 1'b0, 32'h200, 2'd2);
        set_data(2, 32'h201);
        m_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            expect_out($sformatf("bp_stall%0d", s), 4'h0, 1'b1, 1'b0, 32'h201, 2'd2);
        end
        m_ready = 1'b1;
        expect_out("bp_b2", 4'h4, 1'b1, 1'b0, 32'h201, 2'd2);
        set_data(2, 32'h202);
        expect_out("bp_b3", 4'h4, 1'b1, 1'b0, 32'h202, 2'd2);
        set_data(2, 32'h203);
        expect_out("bp_b4", 4'h4, 1'b1, 1'b0, 32'h203, 2'd2);
        set_data(2, 32'h204);
        drive(4'b0100, 4'b0100, 1'b1);
        expect_out("bp_cut", 4'h0, 1'b0, 1'b0, 32'h0, 2'd2);
        expect_out("bp_b5", 4'h4, 1'b1, 1'b1, 32'h204, 2'd2);

        // Burst limit: 6-beat packet from req0 with req3 waiting.
        set_data(0, 32'h300);
        set_data(3, 32'h3F0);
        drive(4'b0001, 4'b0000, 1'b1);
        expect_out("bl_idle", 4'h0, 1'b0, 1'b0, 32'h0, 2'd2);
        drive(4'b1001, 4'b1000, 1'b1);
        for (int b = 0; b < 4; b++) begin
            set_data(0, 32'h300 + 32'(b));
            expect_out($sformatf("bl_b%0d", b + 1), 4'h1, 1'b1, 1'b0, 32'h300 + 32'(b), 2'd0);
        end
        set_data(0, 32'h304);
        expect_out("bl_cut", 4'h0, 1'b0, 1'b0, 32'h0, 2'd0);
        expect_out("bl_r3", 4'h8, 1'b1, 1'b1, 32'h3F0, 2'd3);
        drive(4'b0001, 4'b0000, 1'b1);
        expect_out("bl_idle2", 4'h0, 1'b0, 1'b0, 32'h0, 2'd3);
        expect_out("bl_b5", 4'h1, 1'b1, 1'b0, 32'h304, 2'd0);
        set_data(0, 32'h305);
        drive(4'b0001, 4'b0001, 1'b1);
        expect_out("bl_b6", 4'h1, 1'b1, 1'b1, 32'h305, 2'd0);
        drive(4'b0000, 4'b0000, 1'b1);
        expect_out("bl_done", 4'h0, 1'b0, 1'b0, 32'h0, 2'd0);

        // Reset mid-packet: req1 is abandoned after beat 2; afterwards
        // arbitration starts at req0 even though req1 is also requesting.
        set_data(1, 32'h400);
        drive(4'b0010, 4'b0000, 1'b1);
        expect_out("rst_idle", 4'h0, 1'b0, 1'b0, 32'h0, 2'd0);
        expect_out("rst_b1", 4'h2, 1'b1, 1'b0, 32'h400, 2'd1);
        set_data(1, 32'h401);
        expect_out("rst_b2", 4'h2, 1'b1, 1'b0, 32'h401, 2'd1);
        set_data(1, 32'h402);
        aresetn = 1'b0;
        expect_out("rst_edge", 4'h2, 1'b1, 1'b0, 32'h402, 2'd1);
        aresetn = 1'b1;
        set_data(0, 32'h500);
        set_data(1, 32'h501);
        drive(4'b0011, 4'b0011, 1'b1);
        expect_out("rst_after", 4'h0, 1'b0, 1'b0, 32'h0, 2'd0);
        expect_out("rst_g0", 4'h1, 1'b1, 1'b1, 32'h500, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
